// File: rtl/insfetch_iq.sv
// insfetch_iq: RV32IC fetch unit with a bimodal branch predictor and an
// in-order show-ahead instruction queue feeding the decoder.
module insfetch_iq #(
   parameter int          IQ_DEPTH = 8,
   parameter int          BHT_BITS = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   output logic [31:0]         out_PC,
   output logic                ask_for,
   input  logic                give_you,
   input  logic [31:0]         g_ins,
   output logic                iq_valid,
   output logic [31:0]         iq_addr,
   output logic [31:0]         iq_ins,
   output logic                iq_pred_jmp,
   output logic [31:0]         iq_alt_pc,
   input  logic                dc_ready,
   input  logic                rob_clear,
   input  logic [31:0]         rob_new_pc,
   input  logic                cancel_stuck,
   input  logic [31:0]         jalr_new_pc,
   input  logic                is_res,
   input  logic [BHT_BITS-1:0] res_pc_part,
   input  logic                res_jmp
);

   localparam int PW    = $clog2(IQ_DEPTH);
   localparam int CW    = PW + 1;
   localparam int BHT_N = 1 << BHT_BITS;

   logic [31:0]   pc_q, pc_d;
   logic          stuck_q, stuck_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;

   logic [31:0]   q_addr_q [IQ_DEPTH];
   logic [31:0]   q_ins_q  [IQ_DEPTH];
   logic          q_pred_q [IQ_DEPTH];
   logic [31:0]   q_alt_q  [IQ_DEPTH];

   logic [1:0]    bht_q [BHT_N];

   logic          is_comp, is_jalr, is_jal, is_br;
   logic [31:0]   j_imm, b_imm, cj_imm, cb_imm;
   logic [31:0]   seq_pc, jmp_pc, br_pc;
   logic [BHT_BITS-1:0] bht_idx;
   logic          pred_taken;
   logic          enq_pred;
   logic [31:0]   enq_alt, fetch_pc;
   logic          fetch_stuck;
   logic          enq, deq;
   logic          bht_we;
   logic [1:0]    bht_cur, bht_wdata;

   // Decode the instruction arriving from inscache and pick its successor PC.
   always_comb begin
      is_comp = (g_ins[1:0] != 2'b11);
      j_imm   = {{12{g_ins[31]}}, g_ins[19:12], g_ins[20], g_ins[30:21], 1'b0};
      b_imm   = {{20{g_ins[31]}}, g_ins[7], g_ins[30:25], g_ins[11:8], 1'b0};
      cj_imm  = {{21{g_ins[12]}}, g_ins[8], g_ins[10:9], g_ins[6], g_ins[7],
                 g_ins[2], g_ins[11], g_ins[5:3], 1'b0};
      cb_imm  = {{24{g_ins[12]}}, g_ins[6:5], g_ins[2], g_ins[11:10], g_ins[4:3], 1'b0};

      if (is_comp) begin
         is_jalr = (g_ins[1:0] == 2'b10) && (g_ins[15:13] == 3'b100) && (g_ins[6:2] == 5'b0);
         is_jal  = (g_ins[1:0] == 2'b01) && (g_ins[14:13] == 2'b01);
         is_br   = (g_ins[1:0] == 2'b01) && (g_ins[15:14] == 2'b11);
      end else begin
         is_jalr = (g_ins[6:0] == 7'b1100111);
         is_jal  = (g_ins[6:0] == 7'b1101111);
         is_br   = (g_ins[6:0] == 7'b1100011);
      end

      seq_pc     = pc_q + (is_comp ? 32'd2 : 32'd4);
      jmp_pc     = pc_q + (is_comp ? cj_imm : j_imm);
      br_pc      = pc_q + (is_comp ? cb_imm : b_imm);
      bht_idx    = pc_q[BHT_BITS:1];
      pred_taken = bht_q[bht_idx][1];

      enq_pred    = 1'b0;
      enq_alt     = seq_pc;
      fetch_pc    = seq_pc;
      fetch_stuck = 1'b0;
      if (is_jalr) begin
         fetch_pc    = pc_q;
         fetch_stuck = 1'b1;
      end else if (is_jal) begin
         fetch_pc = jmp_pc;
      end else if (is_br) begin
         enq_pred = pred_taken;
         fetch_pc = pred_taken ? br_pc : seq_pc;
         enq_alt  = pred_taken ? seq_pc : br_pc;
      end
   end

   // Queue handshakes, PC/stuck/pointer next state, and predictor update value.
   always_comb begin
      enq     = rdy_in && !rob_clear && give_you && ask_for;
      deq     = rdy_in && !rob_clear && iq_valid && dc_ready;
      pc_d    = pc_q;
      stuck_d = stuck_q;
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;

      if (rdy_in) begin
         if (rob_clear) begin
            pc_d    = rob_new_pc;
            stuck_d = 1'b0;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
         end else begin
            // A pending jalr blocks fetch, so redirect and enqueue never collide.
            if (stuck_q && cancel_stuck) begin
               pc_d    = jalr_new_pc;
               stuck_d = 1'b0;
            end
            if (enq) begin
               pc_d    = fetch_pc;
               stuck_d = fetch_stuck;
               tail_d  = tail_q + PW'(1);
            end
            if (deq) begin
               head_d = head_q + PW'(1);
            end
            if (enq && !deq) begin
               count_d = count_q + CW'(1);
            end else if (!enq && deq) begin
               count_d = count_q - CW'(1);
            end
         end
      end

      bht_we  = rdy_in && is_res;
      bht_cur = bht_q[res_pc_part];
      if (res_jmp) begin
         bht_wdata = (bht_cur == 2'b11) ? 2'b11 : bht_cur + 2'b01;
      end else begin
         bht_wdata = (bht_cur == 2'b00) ? 2'b00 : bht_cur - 2'b01;
      end
   end

   // Fetch control state and queue pointers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pc_q    <= RESET_PC;
         stuck_q <= 1'b0;
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         pc_q    <= pc_d;
         stuck_q <= stuck_d;
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   // Queue storage; stale entries are masked at the head, so no reset needed.
   always_ff @(posedge clk_in) begin
      if (enq) begin
         q_addr_q[tail_q] <= pc_q;
         q_ins_q[tail_q]  <= g_ins;
         q_pred_q[tail_q] <= enq_pred;
         q_alt_q[tail_q]  <= enq_alt;
      end
   end

   // Bimodal counters start weakly taken; lookups this cycle see the old value.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < BHT_N; i++) begin
            bht_q[i] <= 2'b10;
         end
      end else if (bht_we) begin
         bht_q[res_pc_part] <= bht_wdata;
      end
   end

   // Outputs derive from registered state only.
   always_comb begin
      out_PC      = pc_q;
      ask_for     = !stuck_q && (count_q < CW'(IQ_DEPTH));
      iq_valid    = (count_q != '0);
      iq_addr     = iq_valid ? q_addr_q[head_q] : 32'h0;
      iq_ins      = iq_valid ? q_ins_q[head_q]  : 32'h0;
      iq_pred_jmp = iq_valid ? q_pred_q[head_q] : 1'b0;
      iq_alt_pc   = iq_valid ? q_alt_q[head_q]  : 32'h0;
   end

endmodule

// File: doc/insfetch_iq.md
Name: insfetch_iq

Overview:
Parametrised next-generation fetch unit. Fetches RV32IC instructions from inscache and predicts conditional branches with a configurable 2-bit bimodal table. Fetched instructions go into an in-order instruction queue that decouples fetch from the decoder through a valid/ready handshake. Sits between inscache and decoder; redirected by the ROB (mispredict/flush) and by the RS/ALU (jalr target resolution).

Parameters:
IQ_DEPTH, 8, instruction queue entries (power of two, >=2)
BHT_BITS, 8, log2 predictor entries; index = PC[BHT_BITS:1]
RESET_PC, 32'h0, PC loaded at reset

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global enable; low = all state frozen
out_PC  out  32  fetch address to inscache
ask_for  out  1  fetch request = !stuck && (count < IQ_DEPTH)
give_you  in  1  g_ins valid for out_PC this cycle
g_ins  in  32  fetched instruction (low 16 bits meaningful if compressed)
iq_valid  out  1  queue head valid (count != 0)
iq_addr  out  32  head instruction address
iq_ins  out  32  head instruction
iq_pred_jmp  out  1  head predicted taken
iq_alt_pc  out  32  head not-predicted successor PC
dc_ready  in  1  decoder accepts head this cycle
rob_clear  in  1  flush and redirect
rob_new_pc  in  32  redirect target
cancel_stuck  in  1  jalr target resolved
jalr_new_pc  in  32  resolved jalr target
is_res  in  1  branch outcome valid
res_pc_part  in  BHT_BITS  PC[BHT_BITS:1] of resolved branch
res_jmp  in  1  resolved branch taken

Behaviour:
- Reset (async): PC=RESET_PC, stuck=0, count/head/tail=0, every BHT entry=2'b10 (weakly taken), including the last index. Head outputs read as 0 while the queue is empty.
- rdy_in=0: no state change. No enqueue, dequeue or BHT update. Outputs hold.
- Queue: show-ahead FIFO. Dequeue when iq_valid && dc_ready. Enqueue when give_you && ask_for. Simultaneous enqueue and dequeue leaves count unchanged. Pointers wrap modulo IQ_DEPTH. count width is clog2(IQ_DEPTH)+1.
- A full queue blocks fetch even if a dequeue occurs in the same cycle, so ask_for is purely registered-state based.
- Enqueue entry: addr=PC, ins=g_ins, pred, alt. Compressed instruction iff g_ins[1:0]!=2'b11; sequential PC = PC+2 if compressed, PC+4 otherwise.
- Classification and next-PC on enqueue:
  - jalr (opcode 1100111) or c.jr/c.jalr (quadrant 10, funct3 100, [6:2]=0): stuck=1, PC unchanged.
  - jal (1101111): PC += J-imm. c.j/c.jal (quadrant 01, [14:13]=01): PC += CJ-imm. pred=0, alt=sequential.
  - Conditional: B-type (1100011) or c.beqz/c.bnez (quadrant 01, [15:14]=11). pred = BHT[PC[BHT_BITS:1]][1]. PC = pred ? PC+imm : sequential. alt = the other target.
  - All other instructions: pred=0, PC=sequential, alt=sequential.
- Stuck: no fetch. When cancel_stuck is asserted, PC=jalr_new_pc and stuck=0. Fetch resumes the next cycle.
- rob_clear (highest priority): queue emptied (count/head/tail=0), PC=rob_new_pc, stuck=0. Enqueue, dequeue and cancel_stuck are ignored that cycle.
- BHT update: when is_res=1, saturating increment on taken, saturating decrement otherwise. Updates apply in every rdy_in cycle, including stuck and rob_clear cycles.
- BHT lookup and update to the same index in the same cycle: the lookup sees the old value.

Test Plan:
- Reset, queue empty, stream ADDI 0x00100093 at PC 0,4,8 with dc_ready=0 -> after 8 enqueues ask_for=0, count=8. PC stays 0x20 until dc_ready=1, then fetch resumes next cycle.
- BEQ +16 at PC 0x10, BHT reset state -> pred=1, next PC 0x20, iq_alt_pc=0x14. Then apply three is_res with res_jmp=0 at index 8 -> same branch is predicted not-taken, next PC 0x14.
- c.addi 0x0505 at PC 0 followed by JAL +0x100 at PC 2 -> PCs 0, 2, then 0x102. c.addi is enqueued with addr 0.
- JALR at PC 0x40 -> stuck, ask_for=0. Assert cancel_stuck with jalr_new_pc=0x200 -> next fetch at 0x200.
- Queue holding 5 entries, rob_clear with rob_new_pc=0x80 while give_you=1, dc_ready=1, cancel_stuck=1 -> iq_valid=0 next cycle, PC=0x80, stuck=0.
- Assert rst_in mid-stream (asynchronously, between clock edges) -> outputs clear immediately, PC=RESET_PC. BHT index 255 reads 2'b10.
